q_argmax_unit: RTL and testbench

- Streaming FP32 (IEEE-754 single) max/min selector with argmax/argmin, placed after the target-network output layer.
- Consumes NUMBER_OF_OUTPUT_NODE Q-values, one per valid beat, and reports the extreme value and its action index.
- Feeds the target-Q computation (max over a′) and action selection (argmax).
- Mode is selectable per vector; NaN inputs are handled explicitly.

---
 rtl/q_argmax_unit_pkg.sv | 23 ++
 rtl/fp32_order_compare.sv | 39 +++
 rtl/q_argmax_unit.sv | 107 ++++++++++
 tb/tb_q_argmax_unit.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/q_argmax_unit_pkg.sv
// Shared FP32 field constants, mode and state encodings for the streaming argmax/argmin unit.
package q_argmax_unit_pkg;

  localparam int SIGN_BIT   = 31;
  localparam int EXP_MSB    = 30;
  localparam int EXP_LSB    = 23;
  localparam int MANT_WIDTH = 23;

  localparam logic [31:0] CANONICAL_NAN = 32'h7FC0_0000;

  localparam logic MODE_MAX = 1'b0;
  localparam logic MODE_MIN = 1'b1;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  function automatic logic is_nan(input logic [31:0] x);
    return (&x[EXP_MSB:EXP_LSB]) && (|x[MANT_WIDTH-1:0]);
  endfunction

endpackage

// File: rtl/fp32_order_compare.sv
// Decides whether candidate b displaces current best a, using an integer order key
// (no FP arithmetic); NaNs never displace a number, ties keep a (the lower index).
module fp32_order_compare
  import q_argmax_unit_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mode,
  output logic        b_wins,
  output logic        b_is_nan
);

  logic        a_is_nan;
  logic [31:0] key_a;
  logic [31:0] key_b;

  // -0 folds onto +0 so the two zeros tie and the earlier one is kept.
  function automatic logic [31:0] order_key(input logic [31:0] x);
    logic [31:0] z;
    z = (x == 32'h8000_0000) ? 32'h0000_0000 : x;
    return z[SIGN_BIT] ? ~z : (z | 32'h8000_0000);
  endfunction

  always_comb begin
    a_is_nan = is_nan(a);
    b_is_nan = is_nan(b);
    key_a    = order_key(a);
    key_b    = order_key(b);
    if (b_is_nan)
      b_wins = 1'b0;
    else if (a_is_nan)
      b_wins = 1'b1;
    else if (mode == MODE_MIN)
      b_wins = (key_b < key_a);
    else
      b_wins = (key_b > key_a);
  end

endmodule

// File: rtl/q_argmax_unit.sv
// Streaming FP32 max/min selector: one Q-value per valid beat, reports the extreme value
// and its index one cycle after the last beat of each vector.
module q_argmax_unit #(
  parameter int          DATA_WIDTH            = 32,
  parameter int          NUMBER_OF_OUTPUT_NODE = 3,
  parameter int          INDEX_WIDTH           = 2,
  parameter logic [31:0] CANONICAL_NAN         = q_argmax_unit_pkg::CANONICAL_NAN
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_valid,
  input  logic [DATA_WIDTH-1:0]  i_data,
  input  logic                   i_mode,
  output logic [DATA_WIDTH-1:0]  o_data,
  output logic [INDEX_WIDTH-1:0] o_index,
  output logic                   o_nan,
  output logic                   o_valid
);

  import q_argmax_unit_pkg::*;

  localparam int CNT_W = (NUMBER_OF_OUTPUT_NODE > 1) ? $clog2(NUMBER_OF_OUTPUT_NODE) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUMBER_OF_OUTPUT_NODE - 1);

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic [DATA_WIDTH-1:0]  best_data, best_data_nxt;
  logic [INDEX_WIDTH-1:0] best_idx, best_idx_nxt;
  logic                   mode_q, mode_nxt;
  logic                   load;
  logic                   b_wins;
  logic                   b_is_nan;
  logic                   all_nan;

  fp32_order_compare u_cmp (
    .a        (best_data),
    .b        (i_data),
    .mode     (mode_q),
    .b_wins   (b_wins),
    .b_is_nan (b_is_nan)
  );

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    best_data_nxt = best_data;
    best_idx_nxt  = best_idx;
    mode_nxt      = mode_q;
    load          = 1'b0;
    case (state)
      IDLE: begin
        if (i_valid) begin
          mode_nxt      = i_mode;
          best_data_nxt = i_data;
          best_idx_nxt  = '0;
          cnt_nxt       = CNT_W'(1);
          state_nxt     = ACCUM;
        end
      end
      ACCUM: begin
        if (i_valid) begin
          if (b_wins) begin
            best_data_nxt = i_data;
            best_idx_nxt  = INDEX_WIDTH'(cnt);
          end
          if (cnt == LAST_BEAT) begin
            load      = 1'b1;
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Best stays NaN only when every beat of the vector was NaN.
    all_nan = is_nan(best_data_nxt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      best_data <= '0;
      best_idx  <= '0;
      mode_q    <= MODE_MAX;
      o_data    <= '0;
      o_index   <= '0;
      o_nan     <= 1'b0;
      o_valid   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      best_data <= best_data_nxt;
      best_idx  <= best_idx_nxt;
      mode_q    <= mode_nxt;
      o_valid   <= load;
      if (load) begin
        o_data  <= all_nan ? CANONICAL_NAN : best_data_nxt;
        o_index <= all_nan ? '0 : best_idx_nxt;
        o_nan   <= all_nan;
      end
    end
  end

endmodule

// File: tb/tb_q_argmax_unit.sv
// Self-checking bench for q_argmax_unit: directed vectors plus randomized vectors
// checked against a signed-magnitude ordering model.
module tb_q_argmax_unit;

  localparam int N = 3;

  logic        clk;
  logic        rst_n;
  logic        i_valid;
  logic [31:0] i_data;
  logic        i_mode;
  logic [31:0] o_data;
  logic [1:0]  o_index;
  logic        o_nan;
  logic        o_valid;

  int passed = 0;
  int total  = 0;

  logic [31:0] vec [N];
  logic [31:0] exp_d;
  logic [1:0]  exp_i;
  logic        exp_n;

  q_argmax_unit dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (i_valid),
    .i_data  (i_data),
    .i_mode  (i_mode),
    .o_data  (o_data),
    .o_index (o_index),
    .o_nan   (o_nan),
    .o_valid (o_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  function automatic bit m_is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  // Real-number ordering via signed magnitude: -0 and +0 both map to 0.
  function automatic longint m_value(input logic [31:0] x);
    longint mag;
    mag = longint'(x[30:0]);
    return x[31] ? -mag : mag;
  endfunction

  task automatic model(input logic mode);
    int best;
    best = -1;
    for (int k = 0; k < N; k++) begin
      if (!m_is_nan(vec[k])) begin
        if (best < 0)
          best = k;
        else if (mode ? (m_value(vec[k]) < m_value(vec[best]))
                      : (m_value(vec[k]) > m_value(vec[best])))
          best = k;
      end
    end
    if (best < 0) begin
      exp_d = 32'h7FC0_0000; exp_i = 2'd0; exp_n = 1'b1;
    end else begin
      exp_d = vec[best]; exp_i = 2'(best); exp_n = 1'b0;
    end
  endtask

  // Called just after a negedge; returns at the negedge following the last beat's capture.
  task automatic send(input logic mode, input int gap, input bit toggle, input string tag);
    for (int k = 0; k < N; k++) begin
      i_valid = 1'b1;
      i_data  = vec[k];
      i_mode  = (k > 0 && toggle) ? ~mode : mode;
      @(negedge clk);
      if (k < N - 1) begin
        chk({tag, "_early_valid"}, 32'(o_valid), 32'd0);
        for (int g = 0; g < gap; g++) begin
          i_valid = 1'b0;
          i_data  = $urandom;
          i_mode  = ~mode;
          @(negedge clk);
          chk({tag, "_gap_valid"}, 32'(o_valid), 32'd0);
        end
      end
    end
  endtask

  task automatic check_result(input string tag);
    chk({tag, "_valid"}, 32'(o_valid), 32'd1);
    chk({tag, "_data"},  o_data, exp_d);
    chk({tag, "_index"}, 32'(o_index), 32'(exp_i));
    chk({tag, "_nan"},   32'(o_nan), 32'(exp_n));
  endtask

  task automatic idle_and_hold(input string tag);
    i_valid = 1'b0;
    i_data  = $urandom;
    @(negedge clk);
    chk({tag, "_pulse_end"}, 32'(o_valid), 32'd0);
    chk({tag, "_hold_data"}, o_data, exp_d);
    chk({tag, "_hold_index"}, 32'(o_index), 32'(exp_i));
  endtask

  task automatic set_vec(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    vec[0] = a; vec[1] = b; vec[2] = c;
  endtask

  function automatic logic [31:0] rand_val(input int prev_k);
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 6))
      0: return r;
      1: return {r[31], 8'hFF, (r[22:0] == 23'd0) ? 23'd1 : r[22:0]};
      2: return {r[31], 31'd0};
      3: return {r[31], 8'hFF, 23'd0};
      4: return (prev_k > 0) ? vec[$urandom_range(0, prev_k - 1)] : r;
      5: return {r[31], 8'h7F + 8'(r[1:0]), 23'd0};
      default: return {r[31], 8'(r[9:2] % 8'd250), r[22:0]};
    endcase
  endfunction

  initial begin
    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_data  = 32'h0;
    i_mode  = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_valid", 32'(o_valid), 32'd0);
    chk("reset_data", o_data, 32'd0);
    chk("reset_index", 32'(o_index), 32'd0);
    chk("reset_nan", 32'(o_nan), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    set_vec(32'h3F80_0000, 32'h4000_0000, 32'hBF80_0000);
    exp_d = 32'h4000_0000; exp_i = 2'd1; exp_n = 1'b0;
    send(1'b0, 0, 1'b0, "max_basic");
    check_result("max_basic");
    idle_and_hold("max_basic");

    exp_d = 32'hBF80_0000; exp_i = 2'd2; exp_n = 1'b0;
    send(1'b1, 0, 1'b1, "min_toggle");
    check_result("min_toggle");
    idle_and_hold("min_toggle");

    set_vec(32'h4000_0000, 32'h4000_0000, 32'h3F80_0000);
    exp_d = 32'h4000_0000; exp_i = 2'd0; exp_n = 1'b0;
    send(1'b0, 0, 1'b0, "tie");
    check_result("tie");
    idle_and_hold("tie");

    set_vec(32'h8000_0000, 32'h0000_0000, 32'hBF80_0000);
    exp_d = 32'h8000_0000; exp_i = 2'd0; exp_n = 1'b0;
    send(1'b0, 0, 1'b0, "zero_tie");
    check_result("zero_tie");
    idle_and_hold("zero_tie");

    set_vec(32'h7FC0_0000, 32'hC000_0000, 32'hBF80_0000);
    exp_d = 32'hBF80_0000; exp_i = 2'd2; exp_n = 1'b0;
    send(1'b0, 0, 1'b0, "nan_first");
    check_result("nan_first");
    idle_and_hold("nan_first");

    set_vec(32'h7FC0_0001, 32'h7FC0_0001, 32'h7FC0_0001);
    exp_d = 32'h7FC0_0000; exp_i = 2'd0; exp_n = 1'b1;
    send(1'b0, 0, 1'b0, "all_nan");
    check_result("all_nan");
    idle_and_hold("all_nan");

    set_vec(32'h3F80_0000, 32'h4000_0000, 32'hBF80_0000);
    exp_d = 32'h4000_0000; exp_i = 2'd1; exp_n = 1'b0;
    send(1'b0, 2, 1'b0, "gaps");
    check_result("gaps");

    // Second vector starts in the o_valid cycle; send() checks the 3-cycle spacing.
    set_vec(32'hC040_0000, 32'h4080_0000, 32'h4080_0000);
    exp_d = 32'hC040_0000; exp_i = 2'd0; exp_n = 1'b0;
    send(1'b1, 0, 1'b0, "b2b");
    check_result("b2b");
    idle_and_hold("b2b");

    set_vec(32'h4100_0000, 32'h4110_0000, 32'h0);
    i_valid = 1'b1; i_data = vec[0]; i_mode = 1'b0;
    @(negedge clk);
    i_data = vec[1];
    @(negedge clk);
    i_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_data", o_data, 32'd0);
    chk("rst_mid_index", 32'(o_index), 32'd0);
    chk("rst_mid_valid", 32'(o_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_mid_no_valid", 32'(o_valid), 32'd0);
    end

    set_vec(32'h3F80_0000, 32'h4040_0000, 32'h4000_0000);
    exp_d = 32'h4040_0000; exp_i = 2'd1; exp_n = 1'b0;
    send(1'b0, 0, 1'b0, "after_rst");
    check_result("after_rst");
    idle_and_hold("after_rst");

    for (int v = 0; v < 60; v++) begin
      logic m;
      int   gap;
      bit   b2b;
      m   = 1'($urandom_range(0, 1));
      gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      b2b = 1'($urandom_range(0, 1));
      for (int k = 0; k < N; k++) vec[k] = rand_val(k);
      model(m);
      send(m, gap, 1'($urandom_range(0, 1)), "rand");
      check_result("rand");
      if (!b2b) idle_and_hold("rand");
    end
    idle_and_hold("final");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
